// File: rtl/fir_mac_stage.sv
// Time-multiplexed single-multiplier FIR stage: one sample in, TAPS MAC cycles,
// then a rounded, saturated result with a one-cycle FIR_valid strobe.
module fir_mac_stage #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 8,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              sample_ready,
  input  logic              coef_wr,
  input  logic [AW-1:0]     coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              FIR_valid,
  output logic [OUT_W-1:0]  FIR_out,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  // Handshake: a sample is taken on any rising edge where sample_valid and
  // sample_ready are both high; sample_valid while not ready drops the sample.
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;

  localparam logic [ACC_W:0] HALF = {{(ACC_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [AW:0] TAPS_L = (AW+1)'(TAPS);
  localparam logic [AW-1:0] LAST_IDX = AW'(TAPS-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  x_q [TAPS];
  logic signed [DATA_W-1:0]  x_d [TAPS];
  logic signed [COEF_W-1:0]  c_q [TAPS];
  logic signed [COEF_W-1:0]  c_d [TAPS];
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic                      fir_valid_q, fir_valid_d;
  logic [OUT_W-1:0]          fir_out_q, fir_out_d;
  logic                      overrun_q, overrun_d;

  logic signed [PW-1:0]      prod;
  logic signed [ACC_W:0]     rnd;
  logic signed [ACC_W:0]     r;
  logic [OUT_W-1:0]          sat_r;

  always_comb begin
    prod  = x_q[idx_q] * c_q[idx_q];
    rnd   = $signed({acc_q[ACC_W-1], acc_q} + HALF);
    r     = rnd >>> SHIFT;
    sat_r = r[OUT_W-1:0];
    if (r > MAXV)      sat_r = MAXV[OUT_W-1:0];
    else if (r < MINV) sat_r = MINV[OUT_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    fir_valid_d = 1'b0;
    fir_out_d   = fir_out_q;
    overrun_d   = overrun_q;

    case (state_q)
      S_IDLE: begin
        // A same-cycle coefficient write lands before this sample's MAC pass.
        if (coef_wr && ({1'b0, coef_addr} < TAPS_L)) c_d[coef_addr] = coef_data;
        if (sample_valid) begin
          x_d[0] = sample_in;
          for (int i = 1; i < TAPS; i++) x_d[i] = x_q[i-1];
          acc_d   = '0;
          idx_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        fir_out_d   = sat_r;
        fir_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (sample_valid && (state_q != S_IDLE)) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      acc_q       <= '0;
      idx_q       <= '0;
      fir_valid_q <= 1'b0;
      fir_out_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      fir_valid_q <= fir_valid_d;
      fir_out_q   <= fir_out_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sample_ready = (state_q == S_IDLE);
  assign FIR_valid    = fir_valid_q;
  assign FIR_out      = fir_out_q;
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/fir_mac_stage.md
Name: fir_mac_stage

Overview:
- Time-multiplexed single-multiplier FIR filter. It sits directly upstream of the UART transmit control unit.
- Accepts one signed sample per request and runs TAPS multiply-accumulate cycles.
- Emits a rounded, saturated 16-bit result with a one-cycle FIR_valid pulse.
- FIR_out holds stable until the next result, so the transmit side can load it at any time after the pulse.

Parameters:
- DATA_W, 16: signed sample width (Q1.15).
- COEF_W, 16: signed coefficient width (Q1.15).
- TAPS, 8: number of taps; must be ≥2.
- OUT_W, 16: signed output width.
- SHIFT, 15: right-shift applied to the accumulator before output.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- sample_valid  in  1  request to filter sample_in.
- sample_in  in  DATA_W  signed input sample.
- sample_ready  out  1  high when the block is in IDLE.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  coefficient index.
- coef_data  in  COEF_W  signed coefficient value.
- FIR_valid  out  1  one-cycle result strobe to the transmit CU.
- FIR_out  out  OUT_W  signed filter result, held until the next result.
- overrun  out  1  sticky flag: a sample was dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - Delay line x[0..TAPS-1]=0; coefficients c[]=0; accumulator=0; tap index=0.
  - FIR_valid=0, FIR_out=0, overrun=0, sample_ready=1 once reset releases.
  - Reset asserted mid-computation aborts it; no FIR_valid is produced.
- States: IDLE -> MAC -> OUT -> IDLE.
- IDLE:
  - sample_ready=1.
  - On sample_valid at edge E0: x[0]<=sample_in, x[i]<=x[i-1], acc<=0, idx<=0, state<=MAC.
- MAC:
  - Each edge: acc<=acc+x[idx]*c[idx] (signed), idx<=idx+1.
  - After TAPS edges (E1..E_TAPS), state<=OUT.
- OUT:
  - At edge E_(TAPS+1): FIR_out<=sat(r), FIR_valid<=1, state<=IDLE.
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift).
- Latency: FIR_valid is high in the cycle after edge E_(TAPS+1). It is exactly one cycle wide and is deasserted at the next edge.
- Throughput: one sample per TAPS+2 cycles. A new sample may be accepted in the cycle FIR_valid is high.
- Accumulator width is DATA_W+COEF_W+clog2(TAPS) (35 bits at defaults); there is no internal overflow.
- Saturation: r > 2^(OUT_W-1)-1 gives 0x7FFF; r < -2^(OUT_W-1) gives 0x8000 (at defaults).
- sample_valid outside IDLE: the sample is dropped, overrun<=1 (sticky until reset), and the computation in progress is unaffected.
- Coefficient writes:
  - coef_wr in IDLE with coef_addr<TAPS: c[coef_addr]<=coef_data.
  - coef_addr≥TAPS, or coef_wr outside IDLE: write ignored.
  - coef_wr and sample_valid in the same IDLE cycle: both take effect; the new coefficient is used by that sample's MAC pass.
- FIR_out never changes except at the OUT edge or on reset.

Test Plan:
- Reset then idle -> FIR_out=0x0000, FIR_valid=0, sample_ready=1, overrun=0. No FIR_valid after 50 idle cycles.
- Write c0=0x4000, others 0; one sample 0x2000 ->
  - FIR_valid pulses exactly TAPS+1 edges after acceptance (9 at defaults).
  - FIR_out=0x1000.
  - FIR_valid width is one cycle.
- Write c[k]=0x0100*(k+1); impulse 0x7FFF followed by seven 0x0000 samples -> successive FIR_out = 0x0100, 0x0200, …, 0x0800.
- Saturation:
  - All c=0x7FFF; eight samples of 0x7FFF -> final FIR_out=0x7FFF.
  - All c=0x7FFF; eight samples of 0x8000 -> final FIR_out=0x8000.
- Overrun: sample_valid held for 3 cycles starting at acceptance ->
  - Only the first sample is filtered, with a single FIR_valid pulse.
  - overrun=1 and stays 1.
  - coef_wr issued during MAC leaves coefficients unchanged.
- Reset mid-op: rst=0 for one cycle during MAC ->
  - Outputs clear immediately; FIR_valid never pulses.
  - Coefficients read back as zero behaviour: the next sample gives FIR_out=0x0000.
